// File: rtl/mult_operand_feeder.sv
// ---------------------------------------------------------------------------
// mult_operand_feeder
//
// Upstream stage of the 16x16 multiplier / result-memory block. Operand pairs
// arrive over a valid/ready handshake and are buffered in a small FIFO. They
// are issued to the multiplier one 2^LOGDEPTH-product block at a time. After
// the last pair of a block has been issued and the multiplier pipeline has
// settled, the block read-back is started and its beats are counted before
// the next block may issue.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready   operand pair handshake (in_ready = FIFO not full)
//   in_op0/in_op1       operand pair
//   EN_mult/RDY_mult    issue handshake to the multiplier
//   mult_input0/1       FIFO head operands (0 while the FIFO is empty)
//   EN_blockRead        one-cycle pulse starting the block read-back
//   VALID_memVal        one read-back beat per high cycle
//   busy                high whenever the feeder is not in ISSUE
//   blocks_done         count of completed blocks (wraps)
//   err_timeout         sticky read-back timeout flag
// ---------------------------------------------------------------------------
module mult_operand_feeder #(
    parameter int OP_WIDTH      = 16,
    parameter int FIFO_LOGDEPTH = 2,
    parameter int LOGDEPTH      = 6,
    parameter int SETTLE_CYC    = 8,
    parameter int READ_BEATS    = 64,
    parameter int TIMEOUT_CYC   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] in_op0,
    input  logic [OP_WIDTH-1:0] in_op1,
    output logic                EN_mult,
    input  logic                RDY_mult,
    output logic [OP_WIDTH-1:0] mult_input0,
    output logic [OP_WIDTH-1:0] mult_input1,
    output logic                EN_blockRead,
    input  logic                VALID_memVal,
    output logic                busy,
    output logic [15:0]         blocks_done,
    output logic                err_timeout
);

    localparam int FIFO_DEPTH = 1 << FIFO_LOGDEPTH;
    localparam int SETTLE_W   = $clog2(SETTLE_CYC + 1);
    localparam int BEAT_W     = $clog2(READ_BEATS + 1);
    localparam int IDLE_W     = $clog2(TIMEOUT_CYC + 1);

    localparam logic [FIFO_LOGDEPTH:0] FIFO_FULL_CNT = (FIFO_LOGDEPTH+1)'(FIFO_DEPTH);
    localparam logic [LOGDEPTH-1:0]    ISSUE_LAST    = {LOGDEPTH{1'b1}};
    localparam logic [SETTLE_W-1:0]    SETTLE_LAST   = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [BEAT_W-1:0]      BEATS_LAST    = BEAT_W'(READ_BEATS - 1);
    localparam logic [IDLE_W-1:0]      TIMEOUT_LAST  = IDLE_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_SETTLE,
        ST_REQ,
        ST_DRAIN
    } state_t;

    // FIFO storage and pointers
    logic [OP_WIDTH-1:0]      fifo_op0_q [FIFO_DEPTH];
    logic [OP_WIDTH-1:0]      fifo_op0_d [FIFO_DEPTH];
    logic [OP_WIDTH-1:0]      fifo_op1_q [FIFO_DEPTH];
    logic [OP_WIDTH-1:0]      fifo_op1_d [FIFO_DEPTH];
    logic [FIFO_LOGDEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOGDEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOGDEPTH:0]   count_q, count_d;

    // Control state
    state_t               state_q, state_d;
    logic [LOGDEPTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [15:0]          blocks_done_q, blocks_done_d;
    logic                 err_timeout_q, err_timeout_d;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic en_mult_c;
    logic en_block_read_c;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL_CNT);
    assign push       = in_valid && !fifo_full;
    assign pop        = en_mult_c && RDY_mult;

    // Head operands come straight from storage; there is no bypass, so a
    // pair written this cycle only becomes visible next cycle.
    assign in_ready     = !fifo_full;
    assign mult_input0  = fifo_empty ? '0 : fifo_op0_q[rd_ptr_q];
    assign mult_input1  = fifo_empty ? '0 : fifo_op1_q[rd_ptr_q];
    assign EN_mult      = en_mult_c;
    assign EN_blockRead = en_block_read_c;
    assign busy         = (state_q != ST_ISSUE);
    assign blocks_done  = blocks_done_q;
    assign err_timeout  = err_timeout_q;

    // FIFO next state: push and pop are independent, so a full FIFO still drains.
    always_comb begin
        fifo_op0_d = fifo_op0_q;
        fifo_op1_d = fifo_op1_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_op0_d[wr_ptr_q] = in_op0;
            fifo_op1_d[wr_ptr_q] = in_op1;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Block sequencing: issue a full block, let the pipeline settle, pulse the
    // read request, then count read-back beats or give up after a long silence.
    always_comb begin
        state_d         = state_q;
        issue_cnt_d     = issue_cnt_q;
        settle_cnt_d    = settle_cnt_q;
        beat_cnt_d      = beat_cnt_q;
        idle_cnt_d      = idle_cnt_q;
        blocks_done_d   = blocks_done_q;
        err_timeout_d   = err_timeout_q;
        en_mult_c       = 1'b0;
        en_block_read_c = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                en_mult_c = !fifo_empty;
                if (!fifo_empty && RDY_mult) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == ISSUE_LAST) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_REQ;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_REQ: begin
                en_block_read_c = 1'b1;
                beat_cnt_d      = '0;
                idle_cnt_d      = '0;
                state_d         = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (VALID_memVal) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    idle_cnt_d = '0;
                    if (beat_cnt_q == BEATS_LAST) begin
                        blocks_done_d = blocks_done_q + 16'd1;
                        state_d       = ST_ISSUE;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    // The cycle that brings idle_cnt to TIMEOUT_CYC aborts the block.
                    if (idle_cnt_q == TIMEOUT_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_ISSUE;
            end
        endcase
    end

    // All state registers; reset discards queued pairs and any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_op0_q[i] <= '0;
                fifo_op1_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_ISSUE;
            issue_cnt_q   <= '0;
            settle_cnt_q  <= '0;
            beat_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            blocks_done_q <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            fifo_op0_q    <= fifo_op0_d;
            fifo_op1_q    <= fifo_op1_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            blocks_done_q <= blocks_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_mult_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_mult_operand_feeder
//
// Directed bench for mult_operand_feeder. Every accepted operand pair is
// pushed to a scoreboard queue; a negedge monitor pops and compares it when
// the multiplier handshake completes, and also checks that the head operands
// stay put while the multiplier stalls.
// ---------------------------------------------------------------------------
module tb_mult_operand_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_op0 = '0;
    logic [15:0] in_op1 = '0;
    logic        EN_mult;
    logic        RDY_mult = 1'b0;
    logic [15:0] mult_input0;
    logic [15:0] mult_input1;
    logic        EN_blockRead;
    logic        VALID_memVal = 1'b0;
    logic        busy;
    logic [15:0] blocks_done;
    logic        err_timeout;

    mult_operand_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op0       (in_op0),
        .in_op1       (in_op1),
        .EN_mult      (EN_mult),
        .RDY_mult     (RDY_mult),
        .mult_input0  (mult_input0),
        .mult_input1  (mult_input1),
        .EN_blockRead (EN_blockRead),
        .VALID_memVal (VALID_memVal),
        .busy         (busy),
        .blocks_done  (blocks_done),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb[$];
    int          xfer_count = 0;
    int          last_xfer_cyc = 0;
    bit          stall_prev = 1'b0;
    logic [15:0] held0 = '0;
    logic [15:0] held1 = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic failNow(input string tag, input string what);
        n_cmp++;
        n_err++;
        $error("[TB] FAIL %s: %s", tag, what);
    endtask

    // Scoreboard monitor: compare each transferred pair and check stall hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                checkOutput("stall_en_mult_held", {31'd0, EN_mult}, 32'd1);
                checkOutput("stall_op0_held", {16'd0, mult_input0}, {16'd0, held0});
                checkOutput("stall_op1_held", {16'd0, mult_input1}, {16'd0, held1});
            end
            if (EN_mult && RDY_mult) begin
                if (sb.size() == 0) begin
                    failNow("unexpected_xfer", $sformatf("observed pair 0x%0h, required none", {mult_input0, mult_input1}));
                end else begin
                    checkOutput("xfer_pair", {mult_input0, mult_input1}, sb.pop_front());
                end
                checkOutput("xfer_not_busy", {31'd0, busy}, 32'd0);
                xfer_count++;
                last_xfer_cyc = cyc;
            end
            stall_prev = EN_mult && !RDY_mult;
            held0 = mult_input0;
            held1 = mult_input1;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Offer one pair until accepted; optionally toggle RDY_mult every cycle.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit toggle_rdy);
        int  tries;
        bit  done;
        tries = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_op0 = a;
        in_op1 = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({a, b});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (toggle_rdy) RDY_mult = ~RDY_mult;
            tries++;
            if (!done && tries > 50) begin
                failNow("push_timeout", $sformatf("in_ready observed 0 for %0d cycles, required 1", tries));
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait for the read request, check its position after the last issue,
    // then step into the first DRAIN cycle.
    task automatic waitBlockRead(input string tag, input int exp_xfers);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (EN_blockRead) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            failNow(tag, "EN_blockRead observed 0 for 400 cycles, required a pulse");
        end else begin
            checkOutput({tag, "_delay"}, cyc - last_xfer_cyc, 32'd9);
            checkOutput({tag, "_xfers"}, xfer_count, exp_xfers);
            checkOutput({tag, "_no_en_mult"}, {31'd0, EN_mult}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Drive n read-back beats; a gap cycle follows beat i when i % gap_every == 0.
    task automatic drainBeats(input int n, input int gap_every);
        for (int i = 0; i < n; i++) begin
            VALID_memVal = 1'b1;
            @(negedge clk);
            if (i == 0) checkOutput("blockread_single_pulse", {31'd0, EN_blockRead}, 32'd0);
            @(posedge clk);
            #1;
            VALID_memVal = 1'b0;
            if (gap_every > 0 && (i % gap_every) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_en_mult"}, {31'd0, EN_mult}, 32'd0);
        checkOutput({tag, "_en_blockread"}, {31'd0, EN_blockRead}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_blocks_done"}, {16'd0, blocks_done}, 32'd0);
        checkOutput({tag, "_err_timeout"}, {31'd0, err_timeout}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({tag, "_op0"}, {16'd0, mult_input0}, 32'd0);
        checkOutput({tag, "_op1"}, {16'd0, mult_input1}, 32'd0);
    endtask

    task automatic waitScoreboardEmpty(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) failNow(tag, $sformatf("%0d pairs still queued, required 0", sb.size()));
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Block 1: 64 in-order pairs, plus a 65th that must wait for the next block
        RDY_mult = 1'b1;
        xfer_count = 0;
        for (int i = 0; i < 64; i++) applyStimulus(16'(i), 16'(i + 1), 1'b0);
        applyStimulus(16'h0BEE, 16'h0CAF, 1'b0);
        waitBlockRead("blk1_read", 64);
        checkOutput("blk1_busy_drain", {31'd0, busy}, 32'd1);
        checkOutput("blk1_held_in_drain", {31'd0, EN_mult}, 32'd0);
        drainBeats(63, 3);
        checkOutput("blk1_blocks_before_last", {16'd0, blocks_done}, 32'd0);
        drainBeats(1, 0);
        checkOutput("blk1_blocks_done", {16'd0, blocks_done}, 32'd1);
        checkOutput("blk1_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("blk1_xfers_at_done", xfer_count, 32'd64);
        checkOutput("blk2_head_en_mult", {31'd0, EN_mult}, 32'd1);
        checkOutput("blk2_head_op0", {16'd0, mult_input0}, 32'h0BEE);
        waitScoreboardEmpty("blk2_65th_pending");
        checkOutput("blk2_65th_issued", xfer_count, 32'd65);

        // Block 2: 63 more pairs with RDY_mult toggling every cycle
        for (int i = 0; i < 63; i++) applyStimulus(16'h1000 + 16'(i), 16'($urandom), 1'b1);
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
            RDY_mult = ~RDY_mult;
        end
        RDY_mult = 1'b1;
        waitBlockRead("blk2_read", 128);
        drainBeats(64, 0);
        checkOutput("blk2_blocks_done", {16'd0, blocks_done}, 32'd2);

        // FIFO full: four pairs fit while the multiplier stalls, the fifth waits
        RDY_mult = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(16'h2000 + 16'(i), 16'hA000 + 16'(i), 1'b0);
        in_valid = 1'b1;
        in_op0 = 16'h2004;
        in_op1 = 16'hA004;
        repeat (3) begin
            @(negedge clk);
            checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("full_head_op0", {16'd0, mult_input0}, 32'h2000);
            @(posedge clk);
            #1;
        end
        RDY_mult = 1'b1;
        applyStimulus(16'h2004, 16'hA004, 1'b0);
        waitScoreboardEmpty("full_drain");
        checkOutput("full_xfers", xfer_count, 32'd133);

        // Block 3: complete the block, then let the read-back time out
        for (int i = 0; i < 59; i++) applyStimulus(16'h3000 + 16'(i), 16'h7000 - 16'(i), 1'b0);
        waitBlockRead("blk3_read", 192);
        drainBeats(10, 2);
        repeat (256) @(negedge clk);
        checkOutput("timeout_not_yet", {31'd0, err_timeout}, 32'd0);
        checkOutput("timeout_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("timeout_err", {31'd0, err_timeout}, 32'd1);
        checkOutput("timeout_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("timeout_blocks_same", {16'd0, blocks_done}, 32'd2);
        @(posedge clk);
        #1;
        VALID_memVal = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        VALID_memVal = 1'b0;
        checkOutput("stray_beats_ignored", {16'd0, blocks_done}, 32'd2);
        checkOutput("err_sticky", {31'd0, err_timeout}, 32'd1);

        // Reset in the middle of a read-back
        for (int i = 0; i < 64; i++) applyStimulus(16'h4000 + 16'(i), 16'(i * 3), 1'b0);
        waitBlockRead("blk4_read", 256);
        drainBeats(30, 0);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_drain");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of issuing, with pairs still queued
        for (int i = 0; i < 20; i++) applyStimulus(16'h6000 + 16'(i), 16'h1111, 1'b0);
        RDY_mult = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(16'h6100 + 16'(i), 16'h2222, 1'b0);
        checkOutput("pre_rst_en_mult", {31'd0, EN_mult}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_issue");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fresh block after reset: issue count restarts at zero
        xfer_count = 0;
        RDY_mult = 1'b1;
        for (int i = 0; i < 64; i++) applyStimulus(16'h5000 + 16'(i), 16'hFFFF - 16'(i), 1'b0);
        waitBlockRead("post_rst_read", 64);
        drainBeats(64, 4);
        checkOutput("post_rst_blocks_done", {16'd0, blocks_done}, 32'd1);
        checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("post_rst_err", {31'd0, err_timeout}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
